// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, frame-decoder states and sticky-flag positions for the SPI command sequencer.
package spi_cmd_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_CLEAR  = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_W,
        ADDR_R,
        WDATA,
        RDATA,
        DISCARD
    } state_t;

    // Positions within the 3-bit sticky flag vector, which sits at status[7:5].
    localparam int FLAG_WR_OVF  = 2;
    localparam int FLAG_BAD_CMD = 1;
    localparam int FLAG_RD_LATE = 0;

endpackage

// File: rtl/spi_command_sequencer_if.sv
// SPI byte stream, response path and register bus seen by the command sequencer.
interface spi_command_sequencer_if #(parameter int ADDR_WIDTH = 8);

    logic [7:0]            i_spi_data;
    logic                  i_spi_data_valid;
    logic                  i_spi_start;
    logic                  i_spi_end;
    logic [7:0]            o_response_data;
    logic                  o_response_data_valid;
    logic                  o_reg_req;
    logic                  o_reg_write;
    logic [ADDR_WIDTH-1:0] o_reg_addr;
    logic [7:0]            o_reg_wdata;
    logic                  i_reg_ack;
    logic [7:0]            i_reg_rdata;
    logic [7:0]            o_status;

    modport master (
        input  i_spi_data, i_spi_data_valid, i_spi_start, i_spi_end,
        input  i_reg_ack, i_reg_rdata,
        output o_response_data, o_response_data_valid,
        output o_reg_req, o_reg_write, o_reg_addr, o_reg_wdata, o_status
    );

    modport slave (
        output i_spi_data, i_spi_data_valid, i_spi_start, i_spi_end,
        output i_reg_ack, i_reg_rdata,
        input  o_response_data, o_response_data_valid,
        input  o_reg_req, o_reg_write, o_reg_addr, o_reg_wdata, o_status
    );

endinterface

// File: rtl/reg_bus_master.sv
// Single-outstanding register bus handshake with auto-incrementing address and read capture.
module reg_bus_master #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_master_clk,
    input  logic                  i_reset_n,
    input  logic                  frame_edge,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  issue,
    input  logic                  issue_write,
    input  logic [7:0]            wdata,
    input  logic                  ack,
    input  logic [7:0]            rdata,
    output logic                  busy,
    output logic                  req,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [7:0]            req_wdata,
    output logic                  rd_valid,
    output logic [7:0]            rd_data
);

    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  stale;
    logic                  ack_ok;

    assign ack_ok = ack & req;
    assign busy   = req & ~ack;

    // An orphan completion from an aborted frame must not bump the new frame's address.
    always_comb begin
        cnt_nxt = cnt;
        if (load)
            cnt_nxt = load_addr;
        else if (ack_ok && !stale)
            cnt_nxt = cnt + ADDR_WIDTH'(1);
    end

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt       <= '0;
            req       <= 1'b0;
            write     <= 1'b0;
            addr      <= '0;
            req_wdata <= '0;
            stale     <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (issue) begin
                req       <= 1'b1;
                write     <= issue_write;
                addr      <= cnt_nxt;
                req_wdata <= wdata;
            end else if (ack_ok) begin
                req <= 1'b0;
            end
            if (frame_edge)
                stale <= busy;
            else if (ack_ok)
                stale <= 1'b0;
            rd_valid <= ack_ok & ~write & ~stale;
            if (ack_ok && !write)
                rd_data <= rdata;
        end
    end

endmodule

// File: rtl/spi_command_sequencer.sv
// Frame decoder: turns SPI command/address/payload bytes into register bus transactions and responses.
module spi_command_sequencer
    import spi_cmd_pkg::*;
#(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [4:0] DEVICE_ID  = 5'h01
) (
    input  logic                   i_master_clk,
    input  logic                   i_reset_n,
    spi_command_sequencer_if.master bus
);

    state_t     state, state_nxt;
    logic [2:0] flags, set_flags;
    logic       byte_ev, clr_flags, stat_cmd;
    logic       load, issue, issue_write, busy;
    logic       stat_vld;
    logic [7:0] stat_data, status;
    logic       rd_valid;
    logic [7:0] rd_data;

    assign status  = {flags, DEVICE_ID};
    // A frame boundary strobe overrides any byte arriving in the same cycle.
    assign byte_ev = bus.i_spi_data_valid & ~bus.i_spi_start & ~bus.i_spi_end;

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.i_spi_start)
            state_nxt = CMD;
        else if (bus.i_spi_end)
            state_nxt = IDLE;
        else if (bus.i_spi_data_valid) begin
            case (state)
                CMD: begin
                    case (bus.i_spi_data)
                        CMD_WRITE: state_nxt = ADDR_W;
                        CMD_READ:  state_nxt = ADDR_R;
                        default:   state_nxt = DISCARD;
                    endcase
                end
                ADDR_W:  state_nxt = WDATA;
                ADDR_R:  state_nxt = RDATA;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        load        = 1'b0;
        issue       = 1'b0;
        issue_write = 1'b0;
        set_flags   = '0;
        clr_flags   = 1'b0;
        stat_cmd    = 1'b0;
        if (byte_ev) begin
            case (state)
                CMD: begin
                    stat_cmd  = (bus.i_spi_data == CMD_STATUS);
                    clr_flags = (bus.i_spi_data == CMD_CLEAR);
                    set_flags[FLAG_BAD_CMD] = (bus.i_spi_data > CMD_CLEAR);
                end
                ADDR_W: load = 1'b1;
                ADDR_R: begin
                    load = 1'b1;
                    if (busy) set_flags[FLAG_RD_LATE] = 1'b1;
                    else      issue = 1'b1;
                end
                WDATA: begin
                    if (busy) set_flags[FLAG_WR_OVF] = 1'b1;
                    else begin
                        issue       = 1'b1;
                        issue_write = 1'b1;
                    end
                end
                RDATA: begin
                    if (busy) set_flags[FLAG_RD_LATE] = 1'b1;
                    else      issue = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            flags     <= '0;
            stat_vld  <= 1'b0;
            stat_data <= '0;
        end else begin
            if (clr_flags) flags <= '0;
            else           flags <= flags | set_flags;
            stat_vld <= stat_cmd;
            if (stat_cmd) stat_data <= status;
        end
    end

    reg_bus_master #(.ADDR_WIDTH(ADDR_WIDTH)) u_bus (
        .i_master_clk (i_master_clk),
        .i_reset_n    (i_reset_n),
        .frame_edge   (bus.i_spi_start | bus.i_spi_end),
        .load         (load),
        .load_addr    (bus.i_spi_data[ADDR_WIDTH-1:0]),
        .issue        (issue),
        .issue_write  (issue_write),
        .wdata        (bus.i_spi_data),
        .ack          (bus.i_reg_ack),
        .rdata        (bus.i_reg_rdata),
        .busy         (busy),
        .req          (bus.o_reg_req),
        .write        (bus.o_reg_write),
        .addr         (bus.o_reg_addr),
        .req_wdata    (bus.o_reg_wdata),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data)
    );

    // STATUS responses and read completions can never land in the same cycle.
    assign bus.o_response_data_valid = stat_vld | rd_valid;
    assign bus.o_response_data       = stat_vld ? stat_data : rd_data;
    assign bus.o_status              = status;

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Directed bench for spi_command_sequencer: write/read frames, sticky flags, aborts and reset.
module tb_spi_command_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_command_sequencer_if #(.ADDR_WIDTH(8)) bus();

    spi_command_sequencer #(.ADDR_WIDTH(8), .DEVICE_ID(5'h01)) dut (
        .i_master_clk (clk),
        .i_reset_n    (rst_n),
        .bus          (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_spi_data       = b;
        bus.i_spi_data_valid = 1'b1;
        tick();
        bus.i_spi_data_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.i_spi_start = 1'b1;
        tick();
        bus.i_spi_start = 1'b0;
    endtask

    task automatic pulse_end();
        bus.i_spi_end = 1'b1;
        tick();
        bus.i_spi_end = 1'b0;
    endtask

    task automatic ack(input logic [7:0] d);
        bus.i_reg_ack   = 1'b1;
        bus.i_reg_rdata = d;
        tick();
        bus.i_reg_ack   = 1'b0;
        bus.i_reg_rdata = 8'h00;
    endtask

    initial begin
        bus.i_spi_data       = 8'h00;
        bus.i_spi_data_valid = 1'b0;
        bus.i_spi_start      = 1'b0;
        bus.i_spi_end        = 1'b0;
        bus.i_reg_ack        = 1'b0;
        bus.i_reg_rdata      = 8'h00;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        chk("rst_req",    {7'd0, bus.o_reg_req}, 8'h00);
        chk("rst_write",  {7'd0, bus.o_reg_write}, 8'h00);
        chk("rst_addr",   bus.o_reg_addr, 8'h00);
        chk("rst_wdata",  bus.o_reg_wdata, 8'h00);
        chk("rst_rvalid", {7'd0, bus.o_response_data_valid}, 8'h00);
        chk("rst_rdata",  bus.o_response_data, 8'h00);
        chk("rst_status", bus.o_status, 8'h01);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Write frame, ack two cycles after each request
        pulse_start();
        send(8'h01);
        send(8'h10);
        send(8'hAA);
        chk("w1_req",   {7'd0, bus.o_reg_req}, 8'h01);
        chk("w1_write", {7'd0, bus.o_reg_write}, 8'h01);
        chk("w1_addr",  bus.o_reg_addr, 8'h10);
        chk("w1_wdata", bus.o_reg_wdata, 8'hAA);
        tick();
        chk("w1_hold",  {7'd0, bus.o_reg_req}, 8'h01);
        ack(8'h00);
        chk("w1_drop",  {7'd0, bus.o_reg_req}, 8'h00);
        send(8'hBB);
        chk("w2_req",   {7'd0, bus.o_reg_req}, 8'h01);
        chk("w2_addr",  bus.o_reg_addr, 8'h11);
        chk("w2_wdata", bus.o_reg_wdata, 8'hBB);
        tick();
        ack(8'h00);
        chk("w2_rvalid", {7'd0, bus.o_response_data_valid}, 8'h00);
        pulse_end();
        chk("w_status", bus.o_status, 8'h01);

        // Read frame wrapping 0xFF -> 0x00
        pulse_start();
        send(8'h02);
        send(8'hFF);
        chk("r1_req",   {7'd0, bus.o_reg_req}, 8'h01);
        chk("r1_write", {7'd0, bus.o_reg_write}, 8'h00);
        chk("r1_addr",  bus.o_reg_addr, 8'hFF);
        tick();
        ack(8'h5A);
        chk("r1_rvalid", {7'd0, bus.o_response_data_valid}, 8'h01);
        chk("r1_rdata",  bus.o_response_data, 8'h5A);
        tick();
        chk("r1_pulse",  {7'd0, bus.o_response_data_valid}, 8'h00);
        send(8'h00);
        chk("r2_addr",  bus.o_reg_addr, 8'h00);
        chk("r2_req",   {7'd0, bus.o_reg_req}, 8'h01);
        ack(8'hC3);
        chk("r2_rvalid", {7'd0, bus.o_response_data_valid}, 8'h01);
        chk("r2_rdata",  bus.o_response_data, 8'hC3);
        send(8'h00);
        chk("r3_addr",  bus.o_reg_addr, 8'h01);
        ack(8'h77);
        chk("r3_rdata",  bus.o_response_data, 8'h77);
        pulse_end();

        // Write overflow, STATUS with flag set, CLEAR, STATUS again
        pulse_start();
        send(8'h01);
        send(8'h20);
        send(8'h11);
        send(8'h22);
        chk("ovf_status", bus.o_status, 8'h81);
        chk("ovf_wdata",  bus.o_reg_wdata, 8'h11);
        chk("ovf_addr",   bus.o_reg_addr, 8'h20);
        ack(8'h00);
        tick();
        chk("ovf_noreq",  {7'd0, bus.o_reg_req}, 8'h00);
        pulse_end();
        pulse_start();
        send(8'h00);
        chk("stat1_vld",  {7'd0, bus.o_response_data_valid}, 8'h01);
        chk("stat1_data", bus.o_response_data, 8'h81);
        pulse_end();
        pulse_start();
        send(8'h03);
        chk("clr_status", bus.o_status, 8'h01);
        pulse_end();
        pulse_start();
        send(8'h00);
        chk("stat2_vld",  {7'd0, bus.o_response_data_valid}, 8'h01);
        chk("stat2_data", bus.o_response_data, 8'h01);
        tick();
        chk("stat2_pulse", {7'd0, bus.o_response_data_valid}, 8'h00);
        pulse_end();

        // Unknown command
        pulse_start();
        send(8'h7E);
        chk("bad_status", bus.o_status, 8'h41);
        send(8'h01);
        send(8'h02);
        chk("bad_noreq",  {7'd0, bus.o_reg_req}, 8'h00);
        pulse_end();
        pulse_start();
        send(8'h03);
        pulse_end();
        chk("bad_clr",    bus.o_status, 8'h01);

        // Read aborted by end: orphan completion, no response
        pulse_start();
        send(8'h02);
        send(8'h30);
        pulse_end();
        tick();
        chk("orph_hold",  {7'd0, bus.o_reg_req}, 8'h01);
        chk("orph_addr",  bus.o_reg_addr, 8'h30);
        ack(8'h99);
        chk("orph_drop",  {7'd0, bus.o_reg_req}, 8'h00);
        chk("orph_nostb", {7'd0, bus.o_response_data_valid}, 8'h00);
        pulse_start();
        send(8'h00);
        chk("orph_stat",  bus.o_response_data, 8'h01);
        pulse_end();

        // New frame while orphan outstanding: RD_LATE, orphan discarded
        pulse_start();
        send(8'h02);
        send(8'h40);
        pulse_start();
        send(8'h02);
        send(8'h50);
        chk("late_status", bus.o_status, 8'h21);
        chk("late_addr",   bus.o_reg_addr, 8'h40);
        ack(8'h12);
        chk("late_nostb",  {7'd0, bus.o_response_data_valid}, 8'h00);
        send(8'h00);
        chk("late_next",   bus.o_reg_addr, 8'h50);
        ack(8'h34);
        chk("late_rdata",  bus.o_response_data, 8'h34);
        pulse_end();
        pulse_start();
        send(8'h03);
        pulse_end();

        // Start and end together: start wins
        bus.i_spi_start = 1'b1;
        bus.i_spi_end   = 1'b1;
        tick();
        bus.i_spi_start = 1'b0;
        bus.i_spi_end   = 1'b0;
        send(8'h00);
        chk("se_stat",    {7'd0, bus.o_response_data_valid}, 8'h01);
        pulse_end();

        // Stray ack with nothing outstanding
        ack(8'hEE);
        chk("stray_req",  {7'd0, bus.o_reg_req}, 8'h00);
        chk("stray_vld",  {7'd0, bus.o_response_data_valid}, 8'h00);

        // Reset during an outstanding write
        pulse_start();
        send(8'h01);
        send(8'h60);
        send(8'hAB);
        chk("rw_req",     {7'd0, bus.o_reg_req}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_reqdrop", {7'd0, bus.o_reg_req}, 8'h00);
        chk("rw_addr",    bus.o_reg_addr, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rw_status",  bus.o_status, 8'h01);
        send(8'h00);
        chk("rw_idle",    {7'd0, bus.o_response_data_valid}, 8'h00);
        pulse_start();
        send(8'h00);
        chk("rw_stat",    bus.o_response_data, 8'h01);
        pulse_end();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
